// File: rtl/fir_antialias.sv
// Serial-MAC FIR low-pass filter that sits in front of the decimator.
// Each accepted sample is put through one multiply-accumulate per tap.
// The result is then scaled, saturated and presented with a one-cycle valid_out strobe.
// A sample that arrives while the filter is busy is dropped, and the sticky overrun flag is set.
module fir_antialias #(
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned NUM_TAPS   = 8,
    parameter int unsigned COEF_WIDTH = 16,
    parameter int unsigned COEF_FRAC  = 15,
    parameter logic [NUM_TAPS*COEF_WIDTH-1:0] COEFFS = {8{16'h1000}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] data_out,
    output logic             overrun
);

    localparam int unsigned TAP_W  = $clog2(NUM_TAPS);
    localparam int unsigned PROD_W = WIDTH + COEF_WIDTH;
    // Headroom for the sum of NUM_TAPS full-scale products, so acc never wraps.
    localparam int unsigned ACC_W  = PROD_W + $clog2(NUM_TAPS);

    typedef enum logic [1:0] {StIdle, StMac, StOut} state_e;

    state_e                    state_q, state_d;
    logic signed [WIDTH-1:0]   x_q [NUM_TAPS];
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [TAP_W-1:0]          tap_q, tap_d;
    logic                      valid_out_q, valid_out_d;
    logic [WIDTH-1:0]          data_out_q, data_out_d;
    logic                      overrun_q, overrun_d;

    logic signed [COEF_WIDTH-1:0] coef [NUM_TAPS];
    logic signed [PROD_W-1:0]     prod;
    logic signed [ACC_W-1:0]      shifted;
    logic [ACC_W-WIDTH:0]         upper;
    logic [WIDTH-1:0]             sat;
    logic                         accept;

    for (genvar g = 0; g < NUM_TAPS; g++) begin : g_coef
        assign coef[g] = COEFFS[g*COEF_WIDTH +: COEF_WIDTH];
    end

    assign accept = (state_q == StIdle) && valid_in;

    // Product for the current tap, and the scaled/saturated view of the accumulator.
    always_comb begin
        prod    = x_q[tap_q] * coef[tap_q];
        shifted = acc_q >>> COEF_FRAC;
        upper   = shifted[ACC_W-1:WIDTH-1];
        // The value fits only if every bit above the output sign bit matches the output sign bit.
        if ((&upper) || !(|upper)) begin
            sat = shifted[WIDTH-1:0];
        end else if (shifted[ACC_W-1]) begin
            sat = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            sat = {1'b0, {(WIDTH-1){1'b1}}};
        end
    end

    // Next-state and output logic for the Idle -> Mac -> Out sequence.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        tap_d       = tap_q;
        valid_out_d = 1'b0;
        data_out_d  = data_out_q;
        overrun_d   = overrun_q;
        unique case (state_q)
            StIdle: begin
                if (valid_in) begin
                    acc_d   = '0;
                    tap_d   = '0;
                    state_d = StMac;
                end
            end
            StMac: begin
                acc_d = acc_q + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
                if (tap_q == TAP_W'(NUM_TAPS - 1)) begin
                    tap_d   = '0;
                    state_d = StOut;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
                if (valid_in) overrun_d = 1'b1;
            end
            StOut: begin
                data_out_d  = sat;
                valid_out_d = 1'b1;
                state_d     = StIdle;
                if (valid_in) overrun_d = 1'b1;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, accumulator and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            tap_q       <= '0;
            valid_out_q <= 1'b0;
            data_out_q  <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            tap_q       <= tap_d;
            valid_out_q <= valid_out_d;
            data_out_q  <= data_out_d;
            overrun_q   <= overrun_d;
        end
    end

    // Delay line: shifts only when a sample is accepted, so dropped samples never enter it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_TAPS; i++) x_q[i] <= '0;
        end else if (accept) begin
            x_q[0] <= data_in;
            for (int i = 1; i < NUM_TAPS; i++) x_q[i] <= x_q[i-1];
        end
    end

    assign valid_out = valid_out_q;
    assign data_out  = data_out_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_fir_antialias.sv
// Bench for fir_antialias.
// DUT a uses the default boxcar coefficients, and DUT b uses all-0x7FFF coefficients.
// A reference model computes each expected output with plain integer arithmetic over the accepted-sample history.
module tb_fir_antialias;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        va_in = 1'b0, vb_in = 1'b0;
    logic [15:0] da_in = '0, db_in = '0;
    logic        va_out, vb_out, ova, ovb;
    logic [15:0] qa, qb;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: history of accepted samples (newest at index 0) and coefficients.
    longint hist [2][8];
    longint cof  [2][8];

    fir_antialias dut_a (
        .clk(clk), .rst(rst), .valid_in(va_in), .data_in(da_in),
        .valid_out(va_out), .data_out(qa), .overrun(ova)
    );

    fir_antialias #(.COEFFS({8{16'h7FFF}})) dut_b (
        .clk(clk), .rst(rst), .valid_in(vb_in), .data_in(db_in),
        .valid_out(vb_out), .data_out(qb), .overrun(ovb)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Pass one rising edge and stop on the following falling edge.
    task automatic next_neg();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] ref_out(input int d);
        longint s;
        logic [63:0] r;
        s = 0;
        for (int k = 0; k < 8; k++) s += hist[d][k] * cof[d][k];
        s = s >>> 15;  // floor division by 2^15
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        r = s;
        return r[15:0];
    endfunction

    task automatic push(input int d, input logic [15:0] v);
        longint t;
        t = $signed(v);
        for (int k = 7; k > 0; k--) hist[d][k] = hist[d][k-1];
        hist[d][0] = t;
    endtask

    task automatic clear_hist();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 8; k++) hist[d][k] = 0;
    endtask

    function automatic logic vout(input int d);
        return (d == 0) ? va_out : vb_out;
    endfunction

    function automatic logic [15:0] dout(input int d);
        return (d == 0) ? qa : qb;
    endfunction

    task automatic drive(input int d, input logic v, input logic [15:0] x);
        if (d == 0) begin va_in = v; da_in = x; end
        else        begin vb_in = v; db_in = x; end
    endtask

    // Called on a falling edge. Sends one sample and checks that valid_out stays low
    // after sampling edge e0 and edges e1..e8, then pulses after e9; that e9 pulse is
    // the 10th edge counted inclusively. Then checks the data and idles for gap cycles.
    task automatic send(input int d, input logic [15:0] v, input int gap, input string tag);
        drive(d, 1'b1, v);
        push(d, v);
        for (int i = 0; i <= 9; i++) begin
            next_neg();
            drive(d, 1'b0, '0);
            chk({tag, " valid"}, 16'(vout(d)), 16'(i == 9));
        end
        chk({tag, " data"}, dout(d), ref_out(d));
        repeat (gap) next_neg();
    endtask

    initial begin
        for (int k = 0; k < 8; k++) begin
            cof[0][k] = 4096;
            cof[1][k] = 32767;
        end
        clear_hist();

        // Reset state.
        #2 rst = 1'b0;
        #1;
        chk("rst valid_a", 16'(va_out), 16'd0);
        chk("rst data_a", qa, 16'h0000);
        chk("rst ovr_a", 16'(ova), 16'd0);
        chk("rst valid_b", 16'(vb_out), 16'd0);
        chk("rst data_b", qb, 16'h0000);
        chk("rst ovr_b", 16'(ovb), 16'd0);
        repeat (2) next_neg();
        rst = 1'b1;
        next_neg();

        // Impulse through the boxcar: eight outputs of 0x0800, then 0x0000.
        send(0, 16'h4000, 0, "imp0");
        chk("imp0 value", qa, 16'h0800);
        for (int i = 1; i < 9; i++) send(0, 16'h0000, 0, "imp");
        chk("imp tail", qa, 16'h0000);

        // DC ramp: 125, 250, ... settling at 1000, with 12-cycle spacing.
        for (int i = 0; i < 12; i++) send(0, 16'd1000, 2, "dc");
        chk("dc final", qa, 16'd1000);

        // Floor rounding: +1 settles at 1, and -1 settles at -1.
        for (int i = 0; i < 8; i++) send(0, 16'h0001, 0, "floor+");
        chk("floor+ final", qa, 16'h0001);
        for (int i = 0; i < 8; i++) send(0, 16'hFFFF, 0, "floor-");
        chk("floor- final", qa, 16'hFFFF);

        // Saturation with all-0x7FFF coefficients.
        for (int i = 0; i < 8; i++) send(1, 16'h7FFF, 0, "satp");
        chk("satp final", qb, 16'h7FFF);
        for (int i = 0; i < 8; i++) send(1, 16'h8000, 0, "satn");
        chk("satn final", qb, 16'h8000);

        // Overrun: a second strobe 3 cycles after the first is dropped.
        chk("ovr before", 16'(ova), 16'd0);
        drive(0, 1'b1, 16'h2000);
        push(0, 16'h2000);
        for (int i = 0; i <= 9; i++) begin
            next_neg();
            drive(0, 1'b0, '0);
            if (i == 2) drive(0, 1'b1, 16'h7000);  // sampled on e3, mid-MAC
            chk("ovr valid", 16'(va_out), 16'(i == 9));
        end
        chk("ovr data", qa, ref_out(0));
        chk("ovr flag_a", 16'(ova), 16'd1);
        chk("ovr flag_b", 16'(ovb), 16'd0);
        send(0, 16'h4000, 0, "ovr imp");
        for (int i = 0; i < 8; i++) send(0, 16'h0000, 0, "ovr imp");
        chk("ovr sticky", 16'(ova), 16'd1);

        // Randomized samples on both filters with random gaps.
        for (int i = 0; i < 24; i++) begin
            send(0, 16'($urandom), int'($urandom_range(0, 3)), "rnd_a");
            send(1, 16'($urandom), int'($urandom_range(0, 3)), "rnd_b");
        end

        // Reset in MAC cycle 4: nothing may be emitted, and outputs clear while reset is held.
        drive(0, 1'b1, 16'h5555);
        next_neg();
        drive(0, 1'b0, '0);
        repeat (4) next_neg();
        rst = 1'b0;
        #1;
        chk("mrst data_a", qa, 16'h0000);
        chk("mrst ovr_a", 16'(ova), 16'd0);
        chk("mrst data_b", qb, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            next_neg();
            chk("mrst hold valid", 16'(va_out), 16'd0);
            chk("mrst hold data", qa, 16'h0000);
        end
        clear_hist();
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            next_neg();
            chk("mrst no emit", 16'(va_out), 16'd0);
        end
        send(0, 16'h4000, 0, "post imp0");
        chk("post imp0 value", qa, 16'h0800);
        for (int i = 1; i < 9; i++) send(0, 16'h0000, 0, "post imp");
        chk("post tail", qa, 16'h0000);
        chk("post ovr", 16'(ova), 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
